// File: rtl/inv_shift_rows_seq_pkg.sv
// Shared AES types, column-major row access helpers and the FSM state encoding
// for the sequential InvShiftRows block.
package inv_shift_rows_seq_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_row_t;
  typedef logic [1:0]   row_idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StRow,
    StDone
  } fsm_state_t;

  // Row word is {s[r][0], s[r][1], s[r][2], s[r][3]}; byte s[r][c] sits at bit 127-8*(4c+r).
  function automatic aes_row_t get_row(input aes_state_t state, input row_idx_t r);
    aes_row_t row;
    row = '0;
    for (int c = 0; c < 4; c++) begin
      row[31-8*c -: 8] = state[127-8*(4*c+int'(r)) -: 8];
    end
    return row;
  endfunction

  function automatic aes_state_t put_row(input aes_state_t state, input row_idx_t r,
                                         input aes_row_t row);
    aes_state_t res;
    res = state;
    for (int c = 0; c < 4; c++) begin
      res[127-8*(4*c+int'(r)) -: 8] = row[31-8*c -: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/inv_shift_rows_seq_if.sv
// Start/done handshake and state buses between a requester and the InvShiftRows block.
interface inv_shift_rows_seq_if;
  import inv_shift_rows_seq_pkg::*;

  logic       start;
  aes_state_t state_in;
  logic       ready;
  logic       busy;
  logic       done;
  aes_state_t state_out;

  modport master (
    output start,
    output state_in,
    input  ready,
    input  busy,
    input  done,
    input  state_out
  );

  modport slave (
    input  start,
    input  state_in,
    output ready,
    output busy,
    output done,
    output state_out
  );

endinterface

// File: rtl/inv_row_rotate.sv
// Combinational cyclic right rotation of one state row by idx_row bytes.
module inv_row_rotate
  import inv_shift_rows_seq_pkg::*;
(
  input  row_idx_t idx_row,
  input  aes_row_t row_in,
  output aes_row_t row_out
);

  always_comb begin
    row_out = row_in;
    unique case (idx_row)
      2'd0:    row_out = row_in;
      2'd1:    row_out = {row_in[7:0],  row_in[31:8]};
      2'd2:    row_out = {row_in[15:0], row_in[31:16]};
      2'd3:    row_out = {row_in[23:0], row_in[31:24]};
      default: row_out = row_in;
    endcase
  end

endmodule

// File: rtl/inv_shift_rows_seq.sv
// Sequential AES InvShiftRows: rotates one row of the captured state per clock and
// publishes the result with a one-cycle done pulse.
module inv_shift_rows_seq
  import inv_shift_rows_seq_pkg::*;
#(
  parameter bit FAST_ROW0 = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  inv_shift_rows_seq_if.slave bus
);

  // Row 0 is an identity rotation, so the fast variant simply starts at row 1.
  localparam row_idx_t FirstRow = FAST_ROW0 ? 2'd1 : 2'd0;

  fsm_state_t fsm_q;
  row_idx_t   row_q;
  aes_state_t work_q;
  aes_state_t out_q;

  aes_row_t   row_cur;
  aes_row_t   row_rot;
  aes_state_t work_next;

  assign row_cur   = get_row(work_q, row_q);
  assign work_next = put_row(work_q, row_q, row_rot);

  inv_row_rotate u_rotate (
    .idx_row (row_q),
    .row_in  (row_cur),
    .row_out (row_rot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= StIdle;
      row_q  <= '0;
      work_q <= '0;
      out_q  <= '0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (bus.start) begin
            work_q <= bus.state_in;
            row_q  <= FirstRow;
            fsm_q  <= StRow;
          end
        end
        StRow: begin
          work_q <= work_next;
          // Leave on the last row instead of incrementing, so the counter never wraps.
          if (row_q == 2'd3) begin
            out_q <= work_next;
            fsm_q <= StDone;
          end else begin
            row_q <= row_q + 2'd1;
          end
        end
        StDone: begin
          if (bus.start) begin
            work_q <= bus.state_in;
            row_q  <= FirstRow;
            fsm_q  <= StRow;
          end else begin
            fsm_q <= StIdle;
          end
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

  assign bus.ready     = (fsm_q != StRow);
  assign bus.busy      = (fsm_q == StRow);
  assign bus.done      = (fsm_q == StDone);
  assign bus.state_out = out_q;

endmodule

// File: tb/tb_inv_shift_rows_seq.sv
// Directed bench for inv_shift_rows_seq: a slow (FAST_ROW0=0) and a fast (FAST_ROW0=1)
// instance run the same vectors; latency, pulse count and results are checked.
module tb_inv_shift_rows_seq;
  import inv_shift_rows_seq_pkg::*;

  typedef struct {
    string      name;
    aes_state_t din;
    aes_state_t exp;
  } vec_t;

  localparam aes_state_t V2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam aes_state_t V2_OUT = 128'h000d0a0704010e0b0805020f0c090603;
  localparam aes_state_t V3     = 128'h00050a0f04090e03080d02070c01060b;
  localparam aes_state_t V4     = 128'h00112233445566778899aabbccddeeff;
  localparam aes_state_t V4_OUT = 128'h00ddaa774411eebb885522ffcc996633;
  localparam aes_state_t V5     = 128'h00010000000200000003000000040000;
  localparam aes_state_t V5_OUT = 128'h00040000000100000002000000030000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inv_shift_rows_seq_if bus_s ();
  inv_shift_rows_seq_if bus_f ();

  inv_shift_rows_seq #(.FAST_ROW0(1'b0)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  inv_shift_rows_seq #(.FAST_ROW0(1'b1)) dut_f (.clk(clk), .rst_n(rst_n), .bus(bus_f));

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // k counts edges after the capture edge; done visible at k=4 occupies the 5th cycle.
  task automatic run_one(input string name, input aes_state_t din, input aes_state_t exp);
    int lat_s, lat_f, cnt_s, cnt_f;
    aes_state_t res_s, res_f;
    logic busy0;
    lat_s = -1; lat_f = -1; cnt_s = 0; cnt_f = 0; res_s = '0; res_f = '0;
    bus_s.start = 1'b1; bus_s.state_in = din;
    bus_f.start = 1'b1; bus_f.state_in = din;
    next_cycle();
    bus_s.start = 1'b0; bus_s.state_in = ~din;
    bus_f.start = 1'b0; bus_f.state_in = ~din;
    busy0 = bus_s.busy;
    for (int k = 0; k < 10; k++) begin
      if (bus_s.done) begin
        cnt_s++;
        if (lat_s < 0) begin lat_s = k; res_s = bus_s.state_out; end
      end
      if (bus_f.done) begin
        cnt_f++;
        if (lat_f < 0) begin lat_f = k; res_f = bus_f.state_out; end
      end
      next_cycle();
    end
    check({name, " busy after capture"}, busy0, 1'b1);
    check({name, " slow latency"}, lat_s, 4);
    check({name, " fast latency"}, lat_f, 3);
    check({name, " slow pulses"}, cnt_s, 1);
    check({name, " fast pulses"}, cnt_f, 1);
    check({name, " slow result"}, res_s, exp);
    check({name, " fast result"}, res_f, exp);
  endtask

  initial begin
    int d1, d2, cnt;
    aes_state_t r1, r2, held;
    logic stable, ign_busy, ign_ready;

    vecs[0] = '{"vec2",     V2,       V2_OUT};
    vecs[1] = '{"vec3",     V3,       V2};
    vecs[2] = '{"vec4",     V4,       V4_OUT};
    vecs[3] = '{"row1only", V5,       V5_OUT};
    vecs[4] = '{"allones",  {128{1'b1}}, {128{1'b1}}};

    bus_s.start = 1'b0; bus_s.state_in = '0;
    bus_f.start = 1'b0; bus_f.state_in = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset ready", bus_s.ready, 1'b1);
    check("reset busy", bus_s.busy, 1'b0);
    check("reset done", bus_s.done, 1'b0);
    check("reset state_out", bus_s.state_out, '0);
    check("reset fast ready", bus_f.ready, 1'b1);
    check("reset fast state_out", bus_f.state_out, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_one(vecs[i].name, vecs[i].din, vecs[i].exp);
    end

    // Back-to-back on the slow instance: start held high across two operations.
    d1 = -1; d2 = -1; cnt = 0; r1 = '0; r2 = '0;
    ign_busy = 1'b0; ign_ready = 1'b1;
    bus_s.start = 1'b1; bus_s.state_in = V2;
    next_cycle();
    bus_s.state_in = V3;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) begin ign_busy = bus_s.busy; ign_ready = bus_s.ready; end
      if (bus_s.done) begin
        cnt++;
        if (d1 < 0) begin d1 = k; r1 = bus_s.state_out; end
        else if (d2 < 0) begin d2 = k; r2 = bus_s.state_out; end
      end
      if (k == 8) bus_s.start = 1'b0;
      next_cycle();
    end
    check("b2b busy with start held", ign_busy, 1'b1);
    check("b2b ready with start held", ign_ready, 1'b0);
    check("b2b first done", d1, 4);
    check("b2b second done", d2, 9);
    check("b2b pulses", cnt, 2);
    check("b2b first result", r1, V2_OUT);
    check("b2b second result", r2, V2);

    // Old result held through the next operation; start during ROW ignored.
    held = bus_s.state_out;
    stable = 1'b1; d1 = -1; cnt = 0; r1 = '0;
    bus_s.start = 1'b1; bus_s.state_in = V4;
    next_cycle();
    bus_s.start = 1'b0; bus_s.state_in = '0;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) begin bus_s.start = 1'b1; bus_s.state_in = V5; end
      if (k == 2) begin bus_s.start = 1'b0; bus_s.state_in = V3; end
      if (k < 4 && bus_s.state_out !== held) stable = 1'b0;
      if (bus_s.done) begin
        cnt++;
        if (d1 < 0) begin d1 = k; r1 = bus_s.state_out; end
      end
      if (k > 4 && bus_s.state_out !== V4_OUT) stable = 1'b0;
      if (k > 5) bus_s.state_in = {4{$urandom()}};
      next_cycle();
    end
    check("hold old result", held, V2);
    check("hold stable", stable, 1'b1);
    check("ignore done latency", d1, 4);
    check("ignore pulses", cnt, 1);
    check("ignore result", r1, V4_OUT);

    // Asynchronous reset in the middle of ROW, checked before any further edge.
    bus_s.start = 1'b1; bus_s.state_in = V2;
    bus_f.start = 1'b1; bus_f.state_in = V2;
    next_cycle();
    bus_s.start = 1'b0; bus_f.start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrow reset ready", bus_s.ready, 1'b1);
    check("midrow reset busy", bus_s.busy, 1'b0);
    check("midrow reset done", bus_s.done, 1'b0);
    check("midrow reset state_out", bus_s.state_out, '0);
    check("midrow reset fast busy", bus_f.busy, 1'b0);
    check("midrow reset fast state_out", bus_f.state_out, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus_s.done || bus_f.done) cnt++;
      next_cycle();
    end
    check("no done after abort", cnt, 0);

    run_one("recovery", V2, V2_OUT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
